move_input_arbiter: RTL and testbench

Collects one move selection from each of two players per battle round. Inputs are key lines already passed through per-pin synchronizers. Each key is debounced and edge-detected, and each player's first press per round is latched. When both players have locked, the move pair is offered to the battle FSM over a valid/ready handshake. The block sits between the synchronizer bank and the battle FSM on the DE1-SoC top level.

---
 rtl/battle_input_pkg.sv | 22 ++
 rtl/key_debounce.sv | 37 +++
 rtl/move_input_arbiter.sv | 88 ++++++++
 tb/tb_move_input_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/battle_input_pkg.sv
// Shared types and helpers for the two-player move input path.
// Holds the arbiter state encoding, default debounce depth and a lowest-index encoder.
package battle_input_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        OFFER   = 1'b1
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    // Lowest set bit wins; an all-zero vector encodes as 0.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debounce: level after DEBOUNCE_CYCLES consecutive high samples, immediate release.
// press_pulse is registered, so it fires one edge after the level rises; no backpressure.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic level_out,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt;
    logic          level_q;

    assign level_out = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            level_q     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            if (!key_in) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            level_q     <= level_out;
            press_pulse <= level_out & ~level_q;
        end
    end

endmodule

// File: rtl/move_input_arbiter.sv
// Latches each player's first debounced press per round and offers the pair over valid/ready.
// Lock lands DEBOUNCE_CYCLES+1 edges after first high sample; the offer holds until move_ready.
module move_input_arbiter
    import battle_input_pkg::*;
#(
    parameter  int NUM_KEYS        = 4,
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    localparam int MOVE_W          = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_KEYS-1:0] p1_keys,
    input  logic [NUM_KEYS-1:0] p2_keys,
    input  logic              move_ready,
    output logic              move_valid,
    output logic [MOVE_W-1:0] p1_move,
    output logic [MOVE_W-1:0] p2_move,
    output logic              p1_locked,
    output logic              p2_locked
);

    state_t              state;
    logic [NUM_KEYS-1:0] p1_press;
    logic [NUM_KEYS-1:0] p2_press;
    logic [NUM_KEYS-1:0] p1_level;
    logic [NUM_KEYS-1:0] p2_level;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_keys
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_p1 (
            .clk         (clk),
            .reset       (reset),
            .key_in      (p1_keys[k]),
            .level_out   (p1_level[k]),
            .press_pulse (p1_press[k])
        );
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_p2 (
            .clk         (clk),
            .reset       (reset),
            .key_in      (p2_keys[k]),
            .level_out   (p2_level[k]),
            .press_pulse (p2_press[k])
        );
    end

    // Levels are only needed for edge detection inside the debouncers.
    logic unused_levels;
    assign unused_levels = &{1'b0, p1_level, p2_level};

    assign move_valid = (state == OFFER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            p1_locked <= 1'b0;
            p2_locked <= 1'b0;
            p1_move   <= '0;
            p2_move   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (enable && !p1_locked && (|p1_press)) begin
                        p1_locked <= 1'b1;
                        p1_move   <= MOVE_W'(lowest_set(32'(p1_press)));
                    end
                    if (enable && !p2_locked && (|p2_press)) begin
                        p2_locked <= 1'b1;
                        p2_move   <= MOVE_W'(lowest_set(32'(p2_press)));
                    end
                    if (p1_locked && p2_locked) begin
                        state <= OFFER;
                    end
                end
                OFFER: begin
                    if (move_ready) begin
                        state     <= COLLECT;
                        p1_locked <= 1'b0;
                        p2_locked <= 1'b0;
                        p1_move   <= '0;
                        p2_move   <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_move_input_arbiter.sv
// Directed bench for move_input_arbiter with DEBOUNCE_CYCLES=4, NUM_KEYS=4.
module tb_move_input_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] p1_keys;
    logic [3:0] p2_keys;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] p1_move;
    logic [1:0] p2_move;
    logic       p1_locked;
    logic       p2_locked;

    int n_cmp = 0;
    int n_bad = 0;

    move_input_arbiter #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .p1_keys    (p1_keys),
        .p2_keys    (p2_keys),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .p1_move    (p1_move),
        .p2_move    (p2_move),
        .p1_locked  (p1_locked),
        .p2_locked  (p2_locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic l1, input logic l2,
                             input logic [1:0] m1, input logic [1:0] m2);
        check({tag, ".valid"}, 32'(move_valid), 32'(v));
        check({tag, ".p1_locked"}, 32'(p1_locked), 32'(l1));
        check({tag, ".p2_locked"}, 32'(p2_locked), 32'(l2));
        check({tag, ".p1_move"}, 32'(p1_move), 32'(m1));
        check({tag, ".p2_move"}, 32'(p2_move), 32'(m2));
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        p1_keys    = 4'b0000;
        p2_keys    = 4'b0000;
        move_ready = 1'b0;
        tick(2);
        check_all("reset", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

        // Scenario 1: p1 from edge 0, p2 from edge 3.
        reset   = 1'b0;
        p1_keys = 4'b0010;
        for (int e = 0; e <= 9; e++) begin
            if (e == 3) p2_keys = 4'b1000;
            tick(1);
            if (e == 4) check("s1.p1_early", 32'(p1_locked), 32'd0);
            if (e == 5) begin
                check("s1.p1_lock", 32'(p1_locked), 32'd1);
                check("s1.p1_move", 32'(p1_move), 32'd1);
            end
            if (e == 7) check("s1.p2_early", 32'(p2_locked), 32'd0);
            if (e == 8) begin
                check("s1.p2_lock", 32'(p2_locked), 32'd1);
                check("s1.p2_move", 32'(p2_move), 32'd3);
                check("s1.valid_early", 32'(move_valid), 32'd0);
            end
            if (e == 9) check("s1.valid", 32'(move_valid), 32'd1);
        end

        // Scenario 4: offer held 5 cycles without ready, keys still held.
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_all("s4.hold", 1'b1, 1'b1, 1'b1, 2'd1, 2'd3);
        end
        move_ready = 1'b1;
        tick(1);
        check_all("s4.xfer", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        move_ready = 1'b0;
        tick(10);
        check_all("s4.no_relock", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        p1_keys = 4'b0000;
        p2_keys = 4'b0000;
        tick(2);

        // Scenario 2: glitchy key never reaches 4 consecutive samples.
        for (int i = 0; i < 7; i++) begin
            p1_keys = (i == 3) ? 4'b0000 : 4'b0001;
            tick(1);
            check("s2.glitch", 32'(p1_locked), 32'd0);
        end
        p1_keys = 4'b0000;
        tick(6);
        check("s2.after", 32'(p1_locked), 32'd0);

        // Scenario 3: simultaneous keys pick the lowest index; first choice is final.
        p1_keys = 4'b0110;
        tick(6);
        check("s3.lock", 32'(p1_locked), 32'd1);
        check("s3.move", 32'(p1_move), 32'd1);
        p1_keys = 4'b0000;
        tick(1);
        p1_keys = 4'b1000;
        tick(8);
        check("s3.final", 32'(p1_move), 32'd1);
        p1_keys = 4'b0000;
        p2_keys = 4'b0001;
        tick(6);
        check("s3.p2_lock", 32'(p2_locked), 32'd1);
        tick(1);
        check_all("s3.offer", 1'b1, 1'b1, 1'b1, 2'd1, 2'd0);

        // Scenario 6: reset while offering drops the offer.
        p2_keys = 4'b0000;
        reset   = 1'b1;
        tick(1);
        reset = 1'b0;
        check_all("s6.reset", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick(1);

        // Scenario 5: press while disabled is discarded, held key never relocks.
        enable  = 1'b0;
        p1_keys = 4'b0001;
        tick(8);
        check("s5.disabled", 32'(p1_locked), 32'd0);
        enable = 1'b1;
        tick(8);
        check("s5.held", 32'(p1_locked), 32'd0);
        p1_keys = 4'b0000;
        tick(1);
        p1_keys = 4'b0001;
        tick(5);
        check("s5.repress_early", 32'(p1_locked), 32'd0);
        tick(1);
        check("s5.repress", 32'(p1_locked), 32'd1);
        check("s5.move", 32'(p1_move), 32'd0);

        // Ready high before valid is not a transfer; the offer then completes in one edge.
        move_ready = 1'b1;
        p2_keys    = 4'b0100;
        tick(6);
        check("s6.p2_lock", 32'(p2_locked), 32'd1);
        check("s6.p2_move", 32'(p2_move), 32'd2);
        check("s6.no_valid", 32'(move_valid), 32'd0);
        tick(1);
        check_all("s6.offer", 1'b1, 1'b1, 1'b1, 2'd0, 2'd2);
        tick(1);
        check_all("s6.xfer", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick(6);
        check_all("s6.no_b2b", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
